// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ctrl_pkg
// Brief    : Shared indices for buttons, display sources, reports and switches.
// Revision : 1.0
// ============================================================================
package ctrl_pkg;

    localparam int NUM_BTN    = 5;

    localparam int BTN_C      = 0;
    localparam int BTN_U      = 1;
    localparam int BTN_D      = 2;
    localparam int BTN_L      = 3;
    localparam int BTN_R      = 4;

    localparam int SRC_WATCH  = 0;
    localparam int SRC_SR04   = 1;
    localparam int SRC_DHT11  = 2;

    localparam int RPT_WATCH  = 0;
    localparam int RPT_SR04   = 1;
    localparam int RPT_TEMP   = 2;
    localparam int RPT_HUM    = 3;

    localparam int SW_MODE    = 0;
    localparam int SW_DISP    = 1;
    localparam int SW_SEL_LSB = 2;

endpackage
`default_nettype wire

// File: rtl/rpt_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rpt_rr_arbiter
// Brief    : Coalescing report-request queue with round-robin valid/ready grant.
// Revision : 1.0
// ============================================================================
module rpt_rr_arbiter #(
    parameter int NUM_RPT = 4,
    parameter int RPT_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_RPT-1:0] req,
    input  logic               ready,
    output logic               valid,
    output logic [RPT_W-1:0]   id
);

    logic [NUM_RPT-1:0] pending;
    logic [NUM_RPT-1:0] grant_mask;
    logic [RPT_W-1:0]   rr_ptr;
    logic [RPT_W-1:0]   pick;
    logic               found;
    logic               handshake;
    int                 idx;

    assign handshake  = valid & ready;
    assign grant_mask = handshake ? ({{(NUM_RPT-1){1'b0}}, 1'b1} << id) : '0;

    // First pending request at or after the round-robin pointer, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 0; i < NUM_RPT; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_RPT;
            if (!found && pending[idx]) begin
                found = 1'b1;
                pick  = RPT_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            rr_ptr  <= '0;
            valid   <= 1'b0;
            id      <= '0;
        end else begin
            // A fresh pulse for the granted id re-arms it after the clear.
            pending <= (pending & ~grant_mask) | req;
            if (handshake) begin
                valid  <= 1'b0;
                rr_ptr <= (id == RPT_W'(NUM_RPT - 1)) ? '0 : id + RPT_W'(1);
            end else if (!valid && found) begin
                valid <= 1'b1;
                id    <= pick;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/control_unit_gen.sv
`default_nettype none
// ============================================================================
// Module   : control_unit_gen
// Brief    : Switch/button merge, display selection with auto-rotation,
//            start-pulse routing and report-request arbitration.
// Revision : 1.0
// ============================================================================
module control_unit_gen
    import ctrl_pkg::*;
#(
    parameter int NUM_SW    = 4,
    parameter int NUM_SRC   = 3,
    parameter int NUM_RPT   = 4,
    parameter int SEL_W     = 2,
    parameter int RPT_W     = 2,
    parameter int ROT_TICKS = 3
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic [NUM_SW-1:0]  iSw,
    input  logic [NUM_SW-1:0]  iDecTglSw,
    input  logic               iDecClrSwTgl,
    input  logic [NUM_BTN-1:0] iPhysBtn,
    input  logic [NUM_BTN-1:0] iDecBtn,
    input  logic               iAutoEn,
    input  logic               iTick,
    input  logic [NUM_RPT-1:0] iDecReqRpt,
    input  logic               iRptReady,
    output logic [NUM_SW-1:0]  oSwEff,
    output logic [NUM_BTN-1:0] oBtn,
    output logic [SEL_W-1:0]   oDisplaySelect,
    output logic [NUM_SRC-1:0] oStart,
    output logic               oRptValid,
    output logic [RPT_W-1:0]   oRptId
);

    localparam int CNT_W = (ROT_TICKS > 1) ? $clog2(ROT_TICKS) : 1;

    logic [NUM_SW-1:0] tgl;
    logic [1:0]        sel_raw;
    logic [SEL_W-1:0]  manual_idx;
    logic [SEL_W-1:0]  rot_ptr;
    logic [SEL_W-1:0]  ptr_next;
    logic [SEL_W-1:0]  disp_sel;
    logic [CNT_W-1:0]  tick_cnt;
    logic              auto_q;
    logic              btn_c_d;
    logic              btn_c_rise;

    assign oSwEff         = iSw ^ tgl;
    assign oBtn           = iPhysBtn | iDecBtn;
    assign oDisplaySelect = disp_sel;
    assign sel_raw        = oSwEff[SW_SEL_LSB +: 2];
    assign ptr_next       = (rot_ptr == SEL_W'(NUM_SRC - 1)) ? '0 : rot_ptr + SEL_W'(1);
    assign btn_c_rise     = oBtn[BTN_C] & ~btn_c_d;

    always_comb begin
        manual_idx = SEL_W'(sel_raw);
        if (int'(sel_raw) >= NUM_SRC) begin
            manual_idx = SEL_W'(NUM_SRC - 1);
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            tgl <= '0;
        end else if (iDecClrSwTgl) begin
            tgl <= '0;
        end else begin
            tgl <= tgl ^ iDecTglSw;
        end
    end

    // Entry into auto mode snapshots the manual index; the display shows the
    // pointer only from the cycle after entry.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            auto_q   <= 1'b0;
            rot_ptr  <= '0;
            tick_cnt <= '0;
            disp_sel <= '0;
            btn_c_d  <= 1'b0;
        end else begin
            auto_q   <= iAutoEn;
            btn_c_d  <= oBtn[BTN_C];
            disp_sel <= (iAutoEn && auto_q) ? rot_ptr : manual_idx;
            if (iAutoEn && !auto_q) begin
                rot_ptr  <= manual_idx;
                tick_cnt <= '0;
            end else if (iAutoEn) begin
                if (iTick) begin
                    if (tick_cnt == CNT_W'(ROT_TICKS - 1)) begin
                        tick_cnt <= '0;
                        rot_ptr  <= ptr_next;
                    end else begin
                        tick_cnt <= tick_cnt + CNT_W'(1);
                    end
                end
            end else begin
                tick_cnt <= '0;
            end
        end
    end

    assign oStart[SRC_WATCH] = 1'b0;

    for (genvar k = 1; k < NUM_SRC; k++) begin : g_start
        assign oStart[k] = btn_c_rise & (disp_sel == SEL_W'(k));
    end

    rpt_rr_arbiter #(
        .NUM_RPT (NUM_RPT),
        .RPT_W   (RPT_W)
    ) u_rpt_arb (
        .clk   (iClk),
        .rst   (iRst),
        .req   (iDecReqRpt),
        .ready (iRptReady),
        .valid (oRptValid),
        .id    (oRptId)
    );

endmodule
`default_nettype wire

// File: tb/tb_control_unit_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_unit_gen
// Brief    : Self-checking bench for control_unit_gen with a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_control_unit_gen;

    localparam int NUM_SW    = 4;
    localparam int NUM_SRC   = 3;
    localparam int NUM_RPT   = 4;
    localparam int SEL_W     = 2;
    localparam int RPT_W     = 2;
    localparam int ROT_TICKS = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_SW-1:0]  sw, dec_tgl;
    logic               dec_clr;
    logic [4:0]         pbtn, dbtn;
    logic               auto_en, tick;
    logic [NUM_RPT-1:0] dec_req;
    logic               rpt_ready;
    logic [NUM_SW-1:0]  sw_eff;
    logic [4:0]         btn;
    logic [SEL_W-1:0]   disp;
    logic [NUM_SRC-1:0] start;
    logic               rpt_valid;
    logic [RPT_W-1:0]   rpt_id;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    bit [NUM_SW-1:0]  m_tgl;
    int               m_disp, m_ptr, m_cnt;
    bit               m_auto, m_btnc;
    bit [NUM_RPT-1:0] m_pend;
    int               m_rr, m_id;
    bit               m_valid;

    control_unit_gen #(
        .NUM_SW(NUM_SW), .NUM_SRC(NUM_SRC), .NUM_RPT(NUM_RPT),
        .SEL_W(SEL_W), .RPT_W(RPT_W), .ROT_TICKS(ROT_TICKS)
    ) dut (
        .iClk(clk), .iRst(rst), .iSw(sw), .iDecTglSw(dec_tgl),
        .iDecClrSwTgl(dec_clr), .iPhysBtn(pbtn), .iDecBtn(dbtn),
        .iAutoEn(auto_en), .iTick(tick), .iDecReqRpt(dec_req),
        .iRptReady(rpt_ready), .oSwEff(sw_eff), .oBtn(btn),
        .oDisplaySelect(disp), .oStart(start), .oRptValid(rpt_valid),
        .oRptId(rpt_id)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_tgl = '0; m_disp = 0; m_ptr = 0; m_cnt = 0; m_auto = 0; m_btnc = 0;
        m_pend = '0; m_rr = 0; m_id = 0; m_valid = 0;
    endfunction

    function automatic int manual_index();
        int v;
        v = int'((sw ^ m_tgl) >> 2) & 3;
        return (v >= NUM_SRC) ? NUM_SRC - 1 : v;
    endfunction

    function automatic bit [NUM_SRC-1:0] exp_start();
        bit [NUM_SRC-1:0] s;
        s = '0;
        if ((pbtn[0] | dbtn[0]) && !m_btnc && m_disp != 0) s[m_disp] = 1'b1;
        return s;
    endfunction

    // Applies one clock edge of the specified behaviour to the model.
    function automatic void model_update();
        int               man, first;
        bit               hs;
        bit [NUM_RPT-1:0] np;
        man   = manual_index();
        hs    = m_valid && rpt_ready;
        first = -1;
        for (int i = 0; i < NUM_RPT; i++)
            if (first < 0 && m_pend[(m_rr + i) % NUM_RPT]) first = (m_rr + i) % NUM_RPT;
        m_disp = (auto_en && m_auto) ? m_ptr : man;
        if (auto_en && !m_auto) begin
            m_ptr = man; m_cnt = 0;
        end else if (auto_en) begin
            if (tick) begin
                m_cnt++;
                if (m_cnt == ROT_TICKS) begin
                    m_cnt = 0; m_ptr = (m_ptr + 1) % NUM_SRC;
                end
            end
        end else begin
            m_cnt = 0;
        end
        m_auto = auto_en;
        m_btnc = pbtn[0] | dbtn[0];
        m_tgl  = dec_clr ? '0 : (m_tgl ^ dec_tgl);
        np = m_pend;
        if (hs) np[m_id] = 1'b0;
        np = np | dec_req;
        if (hs) begin
            m_valid = 0; m_rr = (m_id + 1) % NUM_RPT;
        end else if (!m_valid && first >= 0) begin
            m_valid = 1; m_id = first;
        end
        m_pend = np;
    endfunction

    task automatic cyc();
        @(posedge clk);
        if (!rst) model_update();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        sw = '0; dec_tgl = '0; dec_clr = 0; pbtn = '0; dbtn = '0;
        auto_en = 0; tick = 0; dec_req = '0; rpt_ready = 0;
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        idle_inputs();
        rst = 1; model_reset();
        cyc(); cyc();
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (disp !== 2'd0 || rpt_valid !== 1'b0 || rpt_id !== 2'd0 || start !== 3'd0 || sw_eff !== 4'd0) begin
            n_fail++;
            $display("FAIL reset: disp=%0d valid=%0b id=%0d start=%b sw_eff=%b required all 0",
                     disp, rpt_valid, rpt_id, start, sw_eff);
        end
    endtask

    task automatic test_switches();
        do_reset();
        sw = 4'b0110; #1;
        n_tests++;
        if (sw_eff !== 4'b0110) begin n_fail++; $display("FAIL sw_eff_direct: got %b required 0110", sw_eff); end
        cyc();
        n_tests++;
        if (disp !== 2'd1) begin n_fail++; $display("FAIL disp_manual: got %0d required 1", disp); end
        dec_tgl = 4'b0001; cyc(); dec_tgl = 4'b1000; cyc(); dec_tgl = '0; #1;
        n_tests++;
        if (sw_eff !== 4'b1111) begin n_fail++; $display("FAIL sw_eff_toggle: got %b required 1111", sw_eff); end
        cyc();
        n_tests++;
        if (disp !== 2'd2) begin n_fail++; $display("FAIL disp_clamp: got %0d required 2", disp); end
        dec_clr = 1; dec_tgl = 4'b0010; cyc(); dec_clr = 0; dec_tgl = '0; #1;
        n_tests++;
        if (sw_eff !== 4'b0110) begin n_fail++; $display("FAIL sw_eff_clear: got %b required 0110", sw_eff); end
        for (int i = 0; i < 60; i++) begin
            sw = 4'($urandom); pbtn = 5'($urandom); dbtn = 5'($urandom);
            dec_tgl = 4'($urandom) & 4'($urandom) & 4'($urandom);
            dec_clr = ($urandom_range(0, 7) == 0);
            #1;
            n_tests++;
            if (sw_eff !== (sw ^ m_tgl) || btn !== (pbtn | dbtn) || disp !== 2'(m_disp)) begin
                n_fail++;
                $display("FAIL switch_random: sw_eff=%b btn=%b disp=%0d required %b %b %0d",
                         sw_eff, btn, disp, sw ^ m_tgl, pbtn | dbtn, m_disp);
            end
            cyc();
        end
        idle_inputs();
    endtask

    task automatic test_start();
        do_reset();
        sw = 4'b0100; cyc(); cyc();
        pbtn = 5'b00001;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_tests++;
            if (start !== ((i == 0) ? 3'b010 : 3'b000)) begin
                n_fail++; $display("FAIL start_held_sel1 cyc%0d: got %b required %b", i, start, (i == 0) ? 3'b010 : 3'b000);
            end
            if (i == 2) sw = 4'b1000;
            cyc();
        end
        n_tests++;
        if (start !== 3'b000) begin n_fail++; $display("FAIL start_src_change: got %b required 000", start); end
        pbtn = '0; sw = 4'b0000; cyc(); cyc();
        dbtn = 5'b00001;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_tests++;
            if (start !== 3'b000) begin n_fail++; $display("FAIL start_watch cyc%0d: got %b required 000", i, start); end
            cyc();
        end
        dbtn = '0; sw = 4'b1000; cyc(); cyc();
        dbtn = 5'b00001; #1;
        n_tests++;
        if (start !== 3'b100) begin n_fail++; $display("FAIL start_sel2: got %b required 100", start); end
        cyc();
        idle_inputs();
    endtask

    task automatic test_auto_rotate();
        int seen[$];
        int want[4] = '{1, 2, 0, 1};
        do_reset();
        sw = 4'b0100; cyc();
        auto_en = 1; cyc();
        seen.push_back(int'(disp));
        for (int t = 0; t < 9; t++) begin
            tick = 1; cyc(); tick = 0; cyc(); cyc();
            n_tests++;
            if (disp !== 2'(m_disp)) begin n_fail++; $display("FAIL auto_step%0d: got %0d required %0d", t, disp, m_disp); end
            if (int'(disp) != seen[$]) seen.push_back(int'(disp));
        end
        n_tests++;
        if (seen.size() != 4 || seen[0] != want[0] || seen[1] != want[1] || seen[2] != want[2] || seen[3] != want[3]) begin
            n_fail++; $display("FAIL auto_sequence: got %p required 1,2,0,1", seen);
        end
        for (int t = 0; t < 3; t++) begin tick = 1; cyc(); tick = 0; cyc(); end
        cyc();
        n_tests++;
        if (disp !== 2'd2) begin n_fail++; $display("FAIL auto_before_exit: got %0d required 2", disp); end
        auto_en = 0; cyc();
        n_tests++;
        if (disp !== 2'd1) begin n_fail++; $display("FAIL auto_exit: got %0d required 1", disp); end
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 9) == 0) auto_en = ~auto_en;
            if ($urandom_range(0, 15) == 0) sw = 4'($urandom);
            tick = ($urandom_range(0, 2) == 0);
            cyc();
            n_tests++;
            if (disp !== 2'(m_disp)) begin n_fail++; $display("FAIL auto_random: got %0d required %0d", disp, m_disp); end
        end
        idle_inputs();
    endtask

    task automatic test_report();
        int got[$];
        int want[5] = '{0, 1, 2, 3, 2};
        bit repulsed = 0;
        do_reset();
        dec_req = 4'b1111; cyc(); dec_req = '0; cyc();
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (rpt_valid !== 1'b1 || rpt_id !== 2'd0) begin
                n_fail++; $display("FAIL rpt_hold: valid=%0b id=%0d required 1 0", rpt_valid, rpt_id);
            end
            cyc();
        end
        rpt_ready = 1;
        for (int i = 0; i < 30; i++) begin
            if (!repulsed && m_valid && m_id == 2) begin dec_req = 4'b0100; repulsed = 1; end
            #1;
            n_tests++;
            if (rpt_valid !== m_valid || (m_valid && rpt_id !== 2'(m_id))) begin
                n_fail++; $display("FAIL rpt_drain: valid=%0b id=%0d required %0b %0d", rpt_valid, rpt_id, m_valid, m_id);
            end
            if (rpt_valid && rpt_ready) got.push_back(int'(rpt_id));
            cyc();
            dec_req = '0;
        end
        n_tests++;
        if (got.size() != 5 || got[0] != want[0] || got[1] != want[1] || got[2] != want[2]
            || got[3] != want[3] || got[4] != want[4]) begin
            n_fail++; $display("FAIL rpt_order: got %p required 0,1,2,3,2", got);
        end
        for (int i = 0; i < 200; i++) begin
            dec_req = 4'($urandom) & 4'($urandom) & 4'($urandom);
            rpt_ready = $urandom_range(0, 1);
            cyc();
            n_tests++;
            if (rpt_valid !== m_valid || rpt_id !== 2'(m_id)) begin
                n_fail++; $display("FAIL rpt_random: valid=%0b id=%0d required %0b %0d", rpt_valid, rpt_id, m_valid, m_id);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        dec_req = 4'b1111; cyc(); dec_req = '0; cyc(); cyc();
        n_tests++;
        if (rpt_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: valid=%0b required 1", rpt_valid); end
        rst = 1; model_reset(); #1;
        n_tests++;
        if (rpt_valid !== 1'b0 || rpt_id !== 2'd0) begin
            n_fail++; $display("FAIL rst_mid_async: valid=%0b id=%0d required 0 0", rpt_valid, rpt_id);
        end
        cyc(); rst = 0; rpt_ready = 1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            n_tests++;
            if (rpt_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_after: valid=%0b required 0", rpt_valid); end
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        model_reset();
        test_reset();
        test_switches();
        test_start();
        test_auto_rotate();
        test_report();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/control_unit_gen.md
Name: control_unit_gen

Overview:
Parametrised successor of the central control unit. It merges physical switches and buttons with UART-decoder toggle and button pulses, and selects the display source, either manually or by timed auto-rotation. It routes the centre button as an edge-detected start pulse to the selected sensor. Decoder report requests are queued and handed one at a time to the UART report sender through a round-robin valid/ready channel.

Parameters:
NUM_SW, 4, number of switch channels (min 4: [0] watch mode, [1] watch display, [3:2] manual display index)
NUM_SRC, 3, number of display sources (0 = watch, 1..NUM_SRC-1 = sensors)
NUM_RPT, 4, number of report-request channels
SEL_W, 2, width of display index, >= clog2(NUM_SRC)
RPT_W, 2, width of report id, >= clog2(NUM_RPT)
ROT_TICKS, 3, iTick pulses per auto-rotation step, >= 1

Ports:
iClk  in  1  system clock
iRst  in  1  reset, asynchronous, active-high
iSw  in  NUM_SW  physical switches
iDecTglSw  in  NUM_SW  decoder toggle pulses, one per switch
iDecClrSwTgl  in  1  decoder pulse that clears all toggles
iPhysBtn  in  5  physical buttons {R,L,D,U,C}
iDecBtn  in  5  decoder button pulses, same order
iAutoEn  in  1  auto-rotation enable
iTick  in  1  timebase enable pulse
iDecReqRpt  in  NUM_RPT  decoder report-request pulses
iRptReady  in  1  report sender ready
oSwEff  out  NUM_SW  effective switches
oBtn  out  5  merged buttons
oDisplaySelect  out  SEL_W  active display source
oStart  out  NUM_SRC  one-hot sensor start pulse
oRptValid  out  1  report request valid
oRptId  out  RPT_W  report request id

Behaviour:
- Reset: toggle register, rotation pointer, tick counter, pending vector, round-robin pointer and btnC delay all 0. oDisplaySelect=0, oRptValid=0, oRptId=0.
- Toggle register tgl: iDecTglSw[i] flips tgl[i] at the next edge. iDecClrSwTgl clears all bits and wins over a simultaneous toggle.
- oSwEff = iSw ^ tgl, combinational. A toggle pulse is visible at oSwEff one cycle later.
- oBtn = iPhysBtn | iDecBtn, combinational, zero latency.
- Manual index = oSwEff[3:2]. Values >= NUM_SRC clamp to NUM_SRC-1.
- oDisplaySelect is registered, one cycle after the manual index or rotation pointer changes.
- Auto mode is entered on the cycle iAutoEn is first seen high.
  - Rotation pointer loads the current manual index; tick counter clears.
  - Each iTick increments the tick counter. On reaching ROT_TICKS the counter clears and the pointer advances modulo NUM_SRC (NUM_SRC-1 wraps to 0).
  - oDisplaySelect follows the pointer.
- Auto mode exits when iAutoEn drops. oDisplaySelect returns to the manual index next cycle; the tick counter clears.
- Start routing: btnC_d registers oBtn[0].
  - oStart[k] = oBtn[0] & ~btnC_d & (oDisplaySelect==k), for k >= 1.
  - oStart[0] is always 0.
  - A held button produces exactly one pulse. A source change while the button is held produces no new pulse.
- Report queue: a pending bit is set by an iDecReqRpt[i] pulse.
  - Repeat pulses while pending coalesce into one request.
  - When idle with any bit pending, the arbiter registers oRptValid=1 and oRptId = first pending index at or after the rr pointer, wrapping.
  - oRptValid and oRptId hold stable until iRptReady=1 on the same cycle as oRptValid=1 (the handshake).
  - On handshake: the granted bit clears, the rr pointer moves to id+1 mod NUM_RPT, and oRptValid drops for at least one cycle before the next grant.
  - A new pulse for the granted id on the handshake cycle keeps that bit pending.
- iRst asserted mid-operation discards all pending requests and any active valid immediately.

Decomposition:
- Package ctrl_pkg:
  - NUM_BTN=5
  - BTN_C=0, BTN_U=1, BTN_D=2, BTN_L=3, BTN_R=4
  - SRC_WATCH=0, SRC_SR04=1, SRC_DHT11=2
  - RPT_WATCH=0, RPT_SR04=1, RPT_TEMP=2, RPT_HUM=3
  - SW_MODE=0, SW_DISP=1, SW_SEL_LSB=2
- Sub-module rpt_rr_arbiter (NUM_RPT, RPT_W): owns the pending vector, rr pointer and valid/ready output.

Test Plan:
- Reset, then iSw=4'b0110 -> oSwEff=4'b0110. oDisplaySelect=1 one cycle later. oRptValid=0.
- Pulse iDecTglSw[0], then iDecTglSw[3] -> oSwEff=4'b1111 and oDisplaySelect=2 (index 3 clamped). Pulse iDecClrSwTgl together with iDecTglSw[1] -> oSwEff=4'b0110.
- Hold iPhysBtn[C] 5 cycles with select=1 -> oStart=3'b010 for exactly one cycle. Repeat with select=0 -> oStart stays 0.
- iAutoEn=1, manual index 1, ROT_TICKS=3, 9 iTick pulses -> oDisplaySelect sequence 1,2,0,1. Drop iAutoEn -> oDisplaySelect=1 next cycle.
- Pulse iDecReqRpt=4'b1111 with iRptReady=0 for 3 cycles -> oRptValid=1 and oRptId=0 held stable. Then iRptReady=1 -> ids granted 0,1,2,3 in order. A re-pulse of id 2 during its handshake -> id 2 granted again after id 3.
- Assert iRst with oRptValid=1 and bits pending -> oRptValid=0 immediately. No grants after reset release.
